bcd2bin_seq: RTL

- Sequential BCD-to-binary converter; the inverse of the existing bin2bcd_16 path.
- Takes 5 BCD digits (bcd0 = ones ... bcd4 = ten-thousands) and produces a 17-bit binary value.
- Uses reverse double-dabble: one shift per clock, with a start/busy/done handshake.
- Used for keypad/switch decimal entry into the lab datapaths, and as a round-trip checker against bin2bcd_16.

---
 rtl/bcd2bin_pkg.sv | 29 ++
 rtl/bcd_digit_adj.sv | 18 +
 rtl/bcd2bin_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bcd2bin_pkg.sv
// Shared constants, state encoding and digit-legality helper for the
// sequential BCD-to-binary converter.
package bcd2bin_pkg;

    localparam int NDIG  = 5;
    localparam int BIN_W = 17;
    localparam int W_W   = 4 * NDIG + BIN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True when any packed 4-bit field holds a non-decimal code (A..F).
    function automatic logic any_digit_bad(input logic [4*NDIG-1:0] digits);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (digits[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD field: codes of 8 or more
// (a ten that was halved into this digit) are pulled back down by 3.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Conditional subtract-3 on one digit field.
    always_comb begin
        q = d;
        if (d >= 4'd8) begin
            q = d - 4'd3;
        end else begin
            q = d;
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential 5-digit BCD to 17-bit binary converter using reverse
// double-dabble, one shift per clock, with a start/busy/done handshake.
module bcd2bin_seq
    import bcd2bin_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       bcd0,
    input  logic [3:0]       bcd1,
    input  logic [3:0]       bcd2,
    input  logic [3:0]       bcd3,
    input  logic [3:0]       bcd4,
    output logic             busy,
    output logic             done,
    output logic [BIN_W-1:0] bin_out,
    output logic             err
);

    localparam int CNT_W = $clog2(BIN_W);

    state_t              state_r;
    state_t              state_n;
    logic [W_W-1:0]      w_r;
    logic [W_W-1:0]      shift_s;
    logic [W_W-1:0]      w_next_s;
    logic [4*NDIG-1:0]   adj_dig_s;
    logic [4*NDIG-1:0]   digits_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [BIN_W-1:0]    bin_r;
    logic                err_r;
    logic                done_r;
    logic                busy_r;
    logic                bad_s;
    logic                last_s;

    assign digits_s = {bcd4, bcd3, bcd2, bcd1, bcd0};
    assign bad_s    = any_digit_bad(digits_s);
    assign last_s   = (cnt_r == CNT_W'(BIN_W - 1));
    assign shift_s  = w_r >> 1;

    // The BCD LSB falls into the binary MSB; each BCD field is then corrected.
    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (shift_s[BIN_W + 4*i +: 4]),
            .q (adj_dig_s[4*i +: 4])
        );
    end

    assign w_next_s = {adj_dig_s, shift_s[BIN_W-1:0]};

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (bad_s) begin
                        state_n = DONE;
                    end else begin
                        state_n = SHIFT;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_n = DONE;
                end else begin
                    state_n = SHIFT;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            w_r     <= {W_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            bin_r   <= {BIN_W{1'b0}};
            err_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n == SHIFT);
            done_r  <= (state_n == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (bad_s) begin
                            err_r <= 1'b1;
                            bin_r <= {BIN_W{1'b0}};
                        end else begin
                            w_r   <= {digits_s, {BIN_W{1'b0}}};
                            cnt_r <= {CNT_W{1'b0}};
                            err_r <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    w_r   <= w_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        bin_r <= shift_s[BIN_W-1:0];
                    end
                end
                default: begin
                    w_r <= w_r;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bin_out = bin_r;
    assign err     = err_r;

endmodule
